// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   N_REQ   : number of requesters sharing the 4:1 mux
//   IDX_W   : width of an encoded requester index
//   state_t : arbiter FSM states
//   pick_t  : result of a round-robin search {found, idx}
//   rr_pick : first eligible request in search order ptr, ptr+1, ... (mod N_REQ)
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Walk the search order backwards so the candidate closest to ptr is the
    // last one written and therefore wins. Index arithmetic wraps naturally
    // in IDX_W bits.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [IDX_W-1:0] ptr,
                                      input logic [N_REQ-1:0] mask);
        pick_t            res;
        logic [N_REQ-1:0] elig;
        logic [IDX_W-1:0] cand;
        res  = '0;
        elig = req & ~mask;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (elig[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux.sv
// Existing 4:1 single-bit multiplexer.
//   sel : encoded input select
//   in  : four data bits
//   ans : in[sel]
module mux (
    input  logic [1:0] sel,
    input  logic [3:0] in,
    output logic       ans
);

    assign ans = in[sel];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit mux between four requesters.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   req     : request per requester (bit i = requester i)
//   in      : data bit per requester (bit i = requester i)
//   gnt     : registered one-hot grant, zero when idle
//   sel     : encoded granted index, drives the mux select
//   busy    : high while a grant is active
//   ans_q   : registered mux output from the previous cycle
//   ans_vld : ans_q holds data captured during a granted cycle
module mux_rr_arbiter
    import mux_arb_pkg::IDX_W;
    import mux_arb_pkg::state_t;
    import mux_arb_pkg::IDLE;
    import mux_arb_pkg::GRANT;
    import mux_arb_pkg::pick_t;
    import mux_arb_pkg::rr_pick;
#(
    parameter int N_REQ    = 4,   // fixed by the 4:1 mux
    parameter int MAX_HOLD = 4    // 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] in,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] sel,
    output logic             busy,
    output logic             ans_q,
    output logic             ans_vld
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [3:0]       hold_cnt;

    logic             ans;
    logic [N_REQ-1:0] own_mask;
    logic             others;
    logic             hand_off;
    pick_t            idle_pick;
    pick_t            next_pick;

    mux u_mux (
        .sel (sel),
        .in  (in),
        .ans (ans)
    );

    // NOTE: every always_comb output gets a default assignment first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        own_mask  = '0;
        own_mask  = N_REQ'(1) << sel;
        others    = |(req & ~own_mask);
        // Leave the current owner on release, or when its tenure is used up
        // and someone else is waiting.
        hand_off  = !req[sel] || ((hold_cnt == HOLD_MAX) && others);
        idle_pick = rr_pick(req, ptr, '0);
        // After a hand-off the search restarts just past the old owner,
        // which is excluded from this evaluation.
        next_pick = rr_pick(req, sel + IDX_W'(1), own_mask);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            ans_q    <= 1'b0;
            ans_vld  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            // ans_q keeps its last sample once the grant goes away.
            if (busy) begin
                ans_q <= ans;
            end
            ans_vld <= busy;

            case (state)
                IDLE: begin
                    if (idle_pick.found) begin
                        state    <= GRANT;
                        gnt      <= N_REQ'(1) << idle_pick.idx;
                        sel      <= idle_pick.idx;
                        busy     <= 1'b1;
                        hold_cnt <= 4'd1;
                    end
                end
                GRANT: begin
                    if (hand_off) begin
                        ptr <= sel + IDX_W'(1);
                        if (next_pick.found) begin
                            gnt      <= N_REQ'(1) << next_pick.idx;
                            sel      <= next_pick.idx;
                            hold_cnt <= 4'd1;
                        end else begin
                            state    <= IDLE;
                            gnt      <= '0;
                            busy     <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                    // At HOLD_MAX with nobody else waiting the count saturates,
                    // so rotation fires on the first edge another request shows.
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios followed by
// random traffic, compared against a behavioural model built on integer
// owner/pointer/tenure bookkeeping.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] in_bits;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       ans_q;
    logic       ans_vld;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_owner;   // -1 when idle
    int m_sel;
    int m_ptr;
    int m_ten;
    bit m_ans;
    bit m_vld;

    mux_rr_arbiter #(.N_REQ(4), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .in      (in_bits),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .ans_q   (ans_q),
        .ans_vld (ans_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int start, input int excl);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_ptr   = 0;
        m_ten   = 0;
        m_ans   = 1'b0;
        m_vld   = 1'b0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w;
        m_sel   = w;
        m_ten   = 1;
    endtask

    // Advance the model by one clock edge using the inputs seen before it.
    task automatic model_edge(input logic [3:0] r, input logic [3:0] d);
        int w;
        if (m_owner >= 0) m_ans = d[m_sel];
        m_vld = (m_owner >= 0);
        if (m_owner < 0) begin
            w = first_from(r, m_ptr, -1);
            if (w >= 0) model_grant(w);
        end else begin
            int g;
            logic [3:0] rest;
            g    = m_owner;
            rest = r;
            rest[g] = 1'b0;
            if (!r[g] || (m_ten >= MAX_HOLD && rest != 4'b0)) begin
                m_ptr = (g + 1) % 4;
                w = first_from(r, m_ptr, g);
                if (w >= 0) begin
                    model_grant(w);
                end else begin
                    m_owner = -1;
                    m_ten   = 0;
                end
            end else if (m_ten < MAX_HOLD) begin
                m_ten++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check({tag, ".gnt"},      8'(gnt),          8'(exp_gnt));
        check({tag, ".sel"},      8'(sel),          8'(m_sel));
        check({tag, ".busy"},     8'(busy),         8'(m_owner >= 0));
        check({tag, ".ans_q"},    8'(ans_q),        8'(m_ans));
        check({tag, ".ans_vld"},  8'(ans_vld),      8'(m_vld));
        check({tag, ".ptr"},      8'(dut.ptr),      8'(m_ptr));
        check({tag, ".hold_cnt"}, 8'(dut.hold_cnt), 8'(m_ten));
    endtask

    // Called at a falling edge: drive, clock, then check at the next falling edge.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] d);
        req     = r;
        in_bits = d;
        @(posedge clk);
        model_edge(r, d);
        @(negedge clk);
        compare_all(tag);
    endtask

    // Assert reset between edges and verify the outputs clear without a clock.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".gnt"},     8'(gnt),     8'h00);
        check({tag, ".busy"},    8'(busy),    8'h00);
        check({tag, ".ans_vld"}, 8'(ans_vld), 8'h00);
        model_reset();
        req     = 4'b0;
        in_bits = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] cur_req;
        rst_n   = 1'b0;
        req     = 4'b0;
        in_bits = 4'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;

        // Reset mid-grant.
        step("rst_grant", 4'b0010, 4'b0000);
        check("rst_grant.gnt_const", 8'(gnt), 8'h02);
        check("rst_grant.sel_const", 8'(sel), 8'h01);
        step("rst_grant2", 4'b0010, 4'b0000);
        async_reset("rst_mid");

        // Single requester: grant holds, tenure saturates, data flows.
        for (int i = 0; i < 6; i++) begin
            step("single", 4'b0100, 4'b0110);
            check("single.gnt_const", 8'(gnt), 8'h04);
            if (i >= 1) begin
                check("single.ans_const", 8'({ans_vld, ans_q}), 8'h03);
            end
        end
        check("single.sat", 8'(dut.hold_cnt), 8'(MAX_HOLD));
        async_reset("rst_a");

        // Forced rotation with everyone requesting.
        for (int i = 0; i < 20; i++) begin
            step("rotate", 4'b1111, 4'($urandom));
            check("rotate.sel_const", 8'(sel), 8'((i / MAX_HOLD) % 4));
            check("rotate.busy_const", 8'(busy), 8'h01);
        end
        async_reset("rst_b");

        // Early release with no bubble.
        step("early", 4'b0011, 4'b0001);
        step("early", 4'b0011, 4'b0001);
        step("early", 4'b0010, 4'b0010);
        check("early.gnt_const",  8'(gnt),     8'h02);
        check("early.busy_const", 8'(busy),    8'h01);
        check("early.ptr_const",  8'(dut.ptr), 8'h01);
        async_reset("rst_c");

        // Wrap-around of the pointer from 3 back to 0.
        step("wrap", 4'b0100, 4'b1111);
        step("wrap", 4'b1001, 4'b1111);
        check("wrap.gnt3", 8'(gnt), 8'h08);
        step("wrap", 4'b0001, 4'b1111);
        check("wrap.gnt0", 8'(gnt), 8'h01);
        async_reset("rst_d");

        // Return to idle.
        step("idle", 4'b0010, 4'b0010);
        check("idle.gnt1", 8'(gnt), 8'h02);
        step("idle", 4'b0000, 4'b0010);
        check("idle.gnt0",  8'(gnt),     8'h00);
        check("idle.busy0", 8'(busy),    8'h00);
        check("idle.vld1",  8'(ans_vld), 8'h01);
        step("idle", 4'b0000, 4'b0000);
        check("idle.vld0",  8'(ans_vld), 8'h00);

        // Random traffic: requests persist for a few cycles between changes.
        cur_req = 4'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom);
            step("rand", cur_req, 4'($urandom));
            if (i == 200) async_reset("rst_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
